// File: rtl/bcd_multidigit_counter.sv
// Parametrised packed-BCD counter: DIGITS decimal digits, single-cycle carry/borrow ripple.
// Optional macro BCD_COUNTER_DOWN_EN enables decrement; without it the up input is ignored.
module bcd_multidigit_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  co,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic          dir_up;
    logic [DIGITS:0] nines_below;
    logic [W-1:0]  inc_value;
    logic [W-1:0]  step_value;
    logic          terminal;
    logic [W-1:0]  load_value;
    logic          load_bad;
    logic [W-1:0]  count_next;
    logic          ovf_next;
    logic          load_err_next;

`ifdef BCD_COUNTER_DOWN_EN
    logic [DIGITS:0] zeros_below;
    logic [W-1:0]  dec_value;

    assign dir_up = up;
`else
    logic          unused_up;

    assign dir_up    = 1'b1;
    assign unused_up = up;
`endif

    // Increment chain: digit k advances only when every digit below it is 9.
    always_comb begin
        nines_below    = '0;
        nines_below[0] = 1'b1;
        inc_value      = count;
        for (int k = 0; k < DIGITS; k++) begin
            if (nines_below[k]) begin
                inc_value[4*k +: 4] = (count[4*k +: 4] == 4'd9) ? 4'd0
                                                                 : count[4*k +: 4] + 4'd1;
            end
            nines_below[k+1] = nines_below[k] & (count[4*k +: 4] == 4'd9);
        end
    end

`ifdef BCD_COUNTER_DOWN_EN
    // Borrow chain: digit k retreats only when every digit below it is 0.
    always_comb begin
        zeros_below    = '0;
        zeros_below[0] = 1'b1;
        dec_value      = count;
        for (int k = 0; k < DIGITS; k++) begin
            if (zeros_below[k]) begin
                dec_value[4*k +: 4] = (count[4*k +: 4] == 4'd0) ? 4'd9
                                                                 : count[4*k +: 4] - 4'd1;
            end
            zeros_below[k+1] = zeros_below[k] & (count[4*k +: 4] == 4'd0);
        end
    end

    assign terminal   = dir_up ? nines_below[DIGITS] : zeros_below[DIGITS];
    assign step_value = dir_up ? inc_value : dec_value;
`else
    assign terminal   = nines_below[DIGITS] & dir_up;
    assign step_value = inc_value;
`endif

    // Invalid load nibbles (10..15) are replaced by 0 and flagged.
    always_comb begin
        load_value = '0;
        load_bad   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (din[4*k +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_value[4*k +: 4] = din[4*k +: 4];
            end
        end
    end

    assign co = en & ~reset & ~clr & ~load & terminal;

    always_comb begin
        count_next    = count;
        ovf_next      = ovf;
        load_err_next = 1'b0;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next    = load_value;
            load_err_next = load_bad;
        end else if (en) begin
            count_next = step_value;
            ovf_next   = ovf | terminal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_next;
            ovf      <= ovf_next;
            load_err <= load_err_next;
        end
    end

endmodule
